// File: rtl/mdu_pkg.sv
// Shared types and op-class decoders for the EX-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mduop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_div(input mduop_t op);
    return op[2];
  endfunction

  // MUL keeps only the low half, so operand signedness does not affect it.
  function automatic logic is_signed_a(input mduop_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input mduop_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic want_high(input mduop_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
  endfunction

  function automatic logic want_rem(input mduop_t op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits
  // and the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  always_comb begin
    o_rem  = w_shift[XLEN-1:0];
    o_quot = {i_quot[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      o_rem  = w_diff[XLEN-1:0];
      o_quot = {i_quot[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_mdu_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier, restoring
// divider, single-op-in-flight valid/ready handshake with sideband passthrough.
module ex_mdu_unit
  import mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_RADIX = 2,
  parameter int SB_W      = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  mduop_t           in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [SB_W-1:0]  in_sb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [SB_W-1:0]  out_sb,
  output logic             busy,
  output mdu_state_t       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload until then, and flush cancels without transfer.

  localparam int DW = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_RADIX - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  mduop_t          r_op;
  logic [DW-1:0]   r_acc;
  logic [DW-1:0]   r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_divisor;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_res;
  logic [SB_W-1:0] r_sb;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [DW-1:0]   w_a_ext;
  logic [DW-1:0]   w_acc_init;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_fast_res;
  logic [DW-1:0]   w_acc_nxt;
  logic [XLEN-1:0] w_mul_res;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quot_nxt;
  logic [XLEN-1:0] w_div_res;
  logic            w_last;

  assign w_a_neg  = is_signed_a(in_op) & in_a[XLEN-1];
  assign w_b_neg  = is_signed_b(in_op) & in_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~in_a) + XLEN'(1) : in_a;
  assign w_b_mag  = w_b_neg ? (~in_b) + XLEN'(1) : in_b;
  assign w_a_ext  = {{XLEN{w_a_neg}}, in_a};
  assign w_b_zero = (in_b == '0);
  assign w_ovf    = is_signed_a(in_op) && (in_a == INT_MIN) && (in_b == '1);

  // Only the low XLEN multiplier bits are iterated; a negative signed b
  // contributes -a * 2^XLEN, which is preloaded into the accumulator.
  assign w_acc_init = w_b_neg ? ({DW{1'b0}} - {w_a_ext[XLEN-1:0], {XLEN{1'b0}}}) : '0;

  assign w_fast_res = want_rem(in_op) ? (w_b_zero ? in_a : '0)
                                      : (w_b_zero ? '1 : in_a);

  always_comb begin
    w_acc_nxt = r_acc;
    for (int k = 0; k < MUL_RADIX; k++) begin
      if (r_mplier[k]) w_acc_nxt = w_acc_nxt + (r_mcand << k);
    end
  end

  assign w_mul_res = want_high(r_op) ? w_acc_nxt[DW-1:XLEN] : w_acc_nxt[XLEN-1:0];

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quot    (w_quot_nxt)
  );

  assign w_div_res = want_rem(r_op)
                   ? (r_neg_r ? (~w_rem_nxt) + XLEN'(1) : w_rem_nxt)
                   : (r_neg_q ? (~w_quot_nxt) + XLEN'(1) : w_quot_nxt);

  assign w_last = (r_cnt == ((r_state == ST_DIV) ? DIV_LAST : MUL_LAST));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= MDU_MUL;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_res     <= '0;
      r_sb      <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_sb  <= in_sb;
            r_cnt <= '0;
            if (is_div(in_op)) begin
              if (w_b_zero || w_ovf) begin
                r_res   <= w_fast_res;
                r_state <= ST_DONE;
              end else begin
                r_rem     <= '0;
                r_quot    <= w_a_mag;
                r_divisor <= w_b_mag;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_state   <= ST_DIV;
              end
            end else begin
              r_acc    <= w_acc_init;
              r_mcand  <= w_a_ext;
              r_mplier <= in_b;
              r_state  <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << MUL_RADIX;
          r_mplier <= r_mplier >> MUL_RADIX;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_res   <= w_mul_res;
            r_state <= ST_DONE;
          end
        end
        ST_DIV: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_res   <= w_div_res;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_res   = r_res;
  assign out_sb    = r_sb;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_mdu_unit.sv
// Directed bench for ex_mdu_unit (XLEN=32, MUL_RADIX=2): vector table plus
// flush, back-pressure and async-reset sequences.
module tb_ex_mdu_unit;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int SB_W = 8;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  mduop_t          in_op = MDU_MUL;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic [SB_W-1:0] in_sb = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_res;
  logic [SB_W-1:0] out_sb;
  logic            busy;
  mdu_state_t      dbg_state;

  ex_mdu_unit #(.XLEN(XLEN), .MUL_RADIX(2), .SB_W(SB_W)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sb     (in_sb),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sb    (out_sb),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    mduop_t          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SB_W-1:0] sb;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one op, return result, sideband and accept->out_valid latency
  task automatic run_op(input mduop_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [SB_W-1:0] sb, output logic [XLEN-1:0] res,
                        output logic [SB_W-1:0] rsb, output int lat);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_sb = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res;
    rsb = out_sb;
  endtask

  logic [XLEN-1:0] res;
  logic [SB_W-1:0] rsb;
  logic [XLEN-1:0] held_res;
  int              lat;
  int              saw_valid;

  initial begin
    vecs[0]  = '{MDU_MUL,    32'd7,          32'hFFFFFFFD, 8'h01, 32'hFFFFFFEB, 17};
    vecs[1]  = '{MDU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 8'h02, 32'hFFFFFFFE, 17};
    vecs[2]  = '{MDU_MULHSU, 32'hFFFFFFFF,   32'd2,        8'h03, 32'hFFFFFFFF, 17};
    vecs[3]  = '{MDU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 8'h04, 32'h00000000, 17};
    vecs[4]  = '{MDU_MULH,   32'h80000000,   32'h80000000, 8'h05, 32'h40000000, 17};
    vecs[5]  = '{MDU_MULHU,  32'h80000000,   32'd2,        8'h06, 32'h00000001, 17};
    vecs[6]  = '{MDU_MULHSU, 32'd2,          32'hFFFFFFFF, 8'h07, 32'h00000001, 17};
    vecs[7]  = '{MDU_MUL,    32'h12345678,   32'd16,       8'h08, 32'h23456780, 17};
    vecs[8]  = '{MDU_DIV,    32'hFFFFFFF9,   32'd2,        8'h09, 32'hFFFFFFFD, 33};
    vecs[9]  = '{MDU_REM,    32'hFFFFFFF9,   32'd2,        8'h0A, 32'hFFFFFFFF, 33};
    vecs[10] = '{MDU_DIVU,   32'd100,        32'd7,        8'h0B, 32'd14,       33};
    vecs[11] = '{MDU_REMU,   32'd100,        32'd7,        8'h0C, 32'd2,        33};
    vecs[12] = '{MDU_DIV,    32'd7,          32'hFFFFFFFE, 8'h0D, 32'hFFFFFFFD, 33};
    vecs[13] = '{MDU_REM,    32'd7,          32'hFFFFFFFE, 8'h0E, 32'd1,        33};
    vecs[14] = '{MDU_DIVU,   32'h80000000,   32'hFFFFFFFF, 8'h0F, 32'd0,        33};
    vecs[15] = '{MDU_REMU,   32'h80000000,   32'hFFFFFFFF, 8'h10, 32'h80000000, 33};
    vecs[16] = '{MDU_DIV,    32'd5,          32'd0,        8'h11, 32'hFFFFFFFF, 1};
    vecs[17] = '{MDU_REM,    32'd5,          32'd0,        8'h12, 32'd5,        1};
    vecs[18] = '{MDU_DIVU,   32'd5,          32'd0,        8'h13, 32'hFFFFFFFF, 1};
    vecs[19] = '{MDU_REMU,   32'd0,          32'd0,        8'h14, 32'd0,        1};
    vecs[20] = '{MDU_DIV,    32'h80000000,   32'hFFFFFFFF, 8'h15, 32'h80000000, 1};
    vecs[21] = '{MDU_REM,    32'h80000000,   32'hFFFFFFFF, 8'h16, 32'd0,        1};

    // reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_sb", 64'(out_sb), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    arst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      exp_q.push_back(vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sb, res, rsb, lat);
      check($sformatf("v%0d_res", i), 64'(res), 64'(exp_q.pop_front()));
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_sb", i), 64'(rsb), 64'(vecs[i].sb));
      @(posedge clk); #1;
      check($sformatf("v%0d_handoff", i), 64'(out_valid), 64'd0);
    end

    // flush with in_valid in IDLE must not accept
    @(negedge clk);
    in_op = MDU_MUL; in_a = 32'd3; in_b = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    check("idle_flush_in_ready", 64'(in_ready), 64'd1);

    // flush in cycle 5 of a DIV
    @(negedge clk);
    in_op = MDU_DIVU; in_a = 32'd100; in_b = 32'd7; in_sb = 8'h33; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("div_busy_before_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    saw_valid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid++;
    end
    check("flush_no_out_valid", 64'(saw_valid), 64'd0);
    exp_q.push_back(32'd12);
    run_op(MDU_MUL, 32'd3, 32'd4, 8'h44, res, rsb, lat);
    check("post_flush_mul_res", 64'(res), 64'(exp_q.pop_front()));
    check("post_flush_mul_lat", 64'(lat), 64'd17);
    @(posedge clk); #1;

    // flush in DONE with out_ready high drops the result
    @(negedge clk);
    in_op = MDU_DIV; in_a = 32'd5; in_b = 32'd0; in_sb = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fast_done_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_out_valid", 64'(out_valid), 64'd0);
    check("done_flush_in_ready", 64'(in_ready), 64'd1);

    // back-pressure: out_ready low 10 cycles in DONE
    out_ready = 1'b0;
    run_op(MDU_MUL, 32'd6, 32'd9, 8'hA5, res, rsb, lat);
    check("bp_res", 64'(res), 64'd54);
    check("bp_sb", 64'(rsb), 64'hA5);
    held_res = res;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_res", c), 64'(out_res), 64'(held_res));
      check($sformatf("bp%0d_sb", c), 64'(out_sb), 64'hA5);
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);

    // async reset in the middle of a MUL
    @(negedge clk);
    in_op = MDU_MULHU; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_res", 64'(out_res), 64'd0);
    check("arst_out_sb", 64'(out_sb), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    run_op(MDU_REMU, 32'd100, 32'd7, 8'h66, res, rsb, lat);
    check("post_arst_res", 64'(res), 64'd2);
    check("post_arst_lat", 64'(lat), 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
